// File: rtl/wb_data_ram_pkg.sv
// Shared constants and types for the Wishbone data RAM: bus widths, reset level,
// FSM encoding and the latched request record.
package wb_data_ram_pkg;

    localparam int   WB_DW      = 32;
    localparam int   WB_SW      = 4;
    localparam logic RstEnable  = 1'b0;
    localparam logic RstDisable = 1'b1;
    localparam logic RST_ACTIVE = RstEnable;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic             we;
        logic [WB_DW-1:0] adr;
        logic [WB_SW-1:0] sel;
        logic [WB_DW-1:0] dat;
    } wb_req_t;

    // Misaligned, or any address bit above the implemented word range.
    function automatic logic addr_err(input logic [WB_DW-1:0] adr, input int aw);
        return (adr[1:0] != 2'b00) || ((adr >> (aw + 2)) != '0);
    endfunction

endpackage

// File: rtl/wb_data_ram_if.sv
// Classic Wishbone slave bus bundle; signal directions named from the slave side.
interface wb_if;
    import wb_data_ram_pkg::*;

    logic             cyc;
    logic             stb;
    logic             we;
    logic [WB_DW-1:0] adr;
    logic [WB_SW-1:0] sel;
    logic [WB_DW-1:0] dat_i;
    logic [WB_DW-1:0] dat_o;
    logic             ack;
    logic             err;

    modport slave  (input cyc, stb, we, adr, sel, dat_i, output dat_o, ack, err);
    modport master (output cyc, stb, we, adr, sel, dat_i, input dat_o, ack, err);

endinterface

// File: rtl/wb_data_ram_bytewrite.sv
// Single-port synchronous RAM with per-byte write enables and a registered,
// resettable read port that only updates on reads.
module wb_ram_bytewrite
    import wb_data_ram_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WB_SW-1:0] be_i,
    input  logic [WB_DW-1:0] wdata_i,
    output logic [WB_DW-1:0] rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [WB_DW-1:0] mem_q [DEPTH];
    logic [WB_DW-1:0] rdata_q;

    // Contents are never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int i = 0; i < WB_SW; i++) begin
                if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_data_ram.sv
// Wishbone word RAM with programmable wait states; misaligned or out-of-range
// accesses terminate with err and have no side effects.
module wb_data_ram
    import wb_data_ram_pkg::*;
#(
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 1
) (
    input logic clk,
    input logic rst,
    wb_if.slave wb
);

    localparam logic [2:0] CNT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    wb_req_t    req_q, req_d;
    wb_req_t    bus_req, cur;
    logic       ack_q, ack_d, err_q, err_d;
    logic       req, cur_err, enter_resp;
    logic       ram_en;

    assign req = wb.cyc && wb.stb;

    always_comb begin
        bus_req     = '0;
        bus_req.we  = wb.we;
        bus_req.adr = wb.adr;
        bus_req.sel = wb.sel;
        bus_req.dat = wb.dat_i;
    end

    // With zero wait states RESP is entered straight from IDLE, before the
    // latch is loaded, so the live bus must feed the access.
    assign cur     = (state_q == IDLE) ? bus_req : req_q;
    assign cur_err = addr_err(cur.adr, MEM_AW);

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        req_q <= req_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    req_d = bus_req;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                // Losing cyc wins over the counter expiring on the same edge.
                if (!wb.cyc) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        enter_resp = (state_d == RESP);
        ack_d      = enter_resp && !cur_err;
        err_d      = enter_resp && cur_err;
        ram_en     = enter_resp && !cur_err && (rst != RST_ACTIVE);
    end

    wb_ram_bytewrite #(.AW(MEM_AW)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .en_i    (ram_en),
        .we_i    (cur.we),
        .addr_i  (cur.adr[MEM_AW+1:2]),
        .be_i    (cur.sel),
        .wdata_i (cur.dat),
        .rdata_o (wb.dat_o)
    );

    assign wb.ack = ack_q;
    assign wb.err = err_q;

endmodule

// File: tb/tb_wb_data_ram.sv
// Directed vector bench for wb_data_ram: one instance with one wait state,
// one with zero wait states for the back-to-back case.
module tb_wb_data_ram;
    import wb_data_ram_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_if bus1();
    wb_if bus0();

    wb_data_ram #(.MEM_AW(10), .WAIT_STATES(1)) dut1 (.clk(clk), .rst(rst), .wb(bus1));
    wb_data_ram #(.MEM_AW(10), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .wb(bus0));

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [16];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive1(input logic cyc, input logic we, input logic [31:0] adr,
                          input logic [3:0] sel, input logic [31:0] dat);
        bus1.cyc = cyc; bus1.stb = cyc; bus1.we = we;
        bus1.adr = adr; bus1.sel = sel; bus1.dat_i = dat;
    endtask

    task automatic drive0(input logic cyc, input logic we, input logic [31:0] adr,
                          input logic [3:0] sel, input logic [31:0] dat);
        bus0.cyc = cyc; bus0.stb = cyc; bus0.we = we;
        bus0.adr = adr; bus0.sel = sel; bus0.dat_i = dat;
    endtask

    // One request on the one-wait-state instance; termination expected on
    // the second edge after the request is presented.
    task automatic xfer1(input vec_t v, input string tag);
        int   n;
        logic done;
        @(negedge clk);
        drive1(1'b1, v.we, v.adr, v.sel, v.dat);
        n = 0; done = 1'b0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (bus1.ack || bus1.err) done = 1'b1;
        end
        drive1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check({tag, " terminated"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(n), 32'd2);
        check({tag, " ack"}, 32'(bus1.ack), 32'(!v.exp_err));
        check({tag, " err"}, 32'(bus1.err), 32'(v.exp_err));
        check({tag, " dat_o"}, bus1.dat_o, v.exp_rd);
        @(posedge clk); #1;
        check({tag, " pulse end"}, 32'({bus1.ack, bus1.err}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b1, 32'h10,   4'hF, 32'h11223344, 1'b0, 32'h00000000};
        vt[1]  = '{1'b0, 32'h10,   4'h0, 32'h0,        1'b0, 32'h11223344};
        vt[2]  = '{1'b1, 32'h10,   4'h4, 32'h00AA0000, 1'b0, 32'h11223344};
        vt[3]  = '{1'b0, 32'h10,   4'hF, 32'h0,        1'b0, 32'h11AA3344};
        vt[4]  = '{1'b0, 32'h13,   4'hF, 32'h0,        1'b1, 32'h11AA3344};
        vt[5]  = '{1'b0, 32'h1000, 4'hF, 32'h0,        1'b1, 32'h11AA3344};
        vt[6]  = '{1'b1, 32'h13,   4'hF, 32'hFFFFFFFF, 1'b1, 32'h11AA3344};
        vt[7]  = '{1'b1, 32'h20,   4'hF, 32'hDEADBEEF, 1'b0, 32'h11AA3344};
        vt[8]  = '{1'b0, 32'h20,   4'h0, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[9]  = '{1'b0, 32'h10,   4'h0, 32'h0,        1'b0, 32'h11AA3344};
        vt[10] = '{1'b1, 32'hFFC,  4'hF, 32'hCAFEF00D, 1'b0, 32'h11AA3344};
        vt[11] = '{1'b0, 32'hFFC,  4'h0, 32'h0,        1'b0, 32'hCAFEF00D};
        vt[12] = '{1'b1, 32'h20,   4'h1, 32'h00000011, 1'b0, 32'hCAFEF00D};
        vt[13] = '{1'b0, 32'h20,   4'h0, 32'h0,        1'b0, 32'hDEADBE11};
        vt[14] = '{1'b1, 32'h20,   4'h8, 32'h77000000, 1'b0, 32'hDEADBE11};
        vt[15] = '{1'b0, 32'h20,   4'h0, 32'h0,        1'b0, 32'h77ADBE11};

        rst = 1'b0;
        drive1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset ack",   32'(bus1.ack), 32'd0);
        check("reset err",   32'(bus1.err), 32'd0);
        check("reset dat_o", bus1.dat_o,    32'd0);
        check("reset dat_o ws0", bus0.dat_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) xfer1(vt[i], $sformatf("vec%0d", i));

        // Abort: cyc drops while waiting, so the write must never land.
        @(negedge clk);
        drive1(1'b1, 1'b1, 32'h10, 4'hF, 32'h00000000);
        @(negedge clk);
        drive1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("abort quiet c%0d", k), 32'({bus1.ack, bus1.err}), 32'd0);
        end
        xfer1('{1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 32'h11AA3344}, "abort readback");

        // Reset landing while the read response is on the bus.
        @(negedge clk);
        drive1(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst-in-resp ack before", 32'(bus1.ack), 32'd1);
        check("rst-in-resp dat before", bus1.dat_o, 32'h77ADBE11);
        rst = 1'b0;
        drive1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        check("rst-in-resp ack after", 32'(bus1.ack), 32'd0);
        check("rst-in-resp dat after", bus1.dat_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        xfer1('{1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 32'h77ADBE11}, "post-reset read");

        // Reset on the edge that would commit a pending write discards it.
        @(negedge clk);
        drive1(1'b1, 1'b1, 32'h20, 4'hF, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        check("rst-in-wait no ack", 32'({bus1.ack, bus1.err}), 32'd0);
        xfer1('{1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 32'h77ADBE11}, "rst-in-wait readback");

        // Zero wait states, request held: responses on alternate cycles.
        @(negedge clk);
        drive0(1'b1, 1'b1, 32'h40, 4'hF, 32'h12345678);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("ws0 wr ack c%0d", k), 32'(bus0.ack), 32'(k % 2 == 0));
            check($sformatf("ws0 wr err c%0d", k), 32'(bus0.err), 32'd0);
        end
        @(negedge clk);
        bus0.we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("ws0 rd ack c%0d", k), 32'(bus0.ack), 32'(k % 2 == 0));
            if (k % 2 == 0) check($sformatf("ws0 rd dat c%0d", k), bus0.dat_o, 32'h12345678);
        end
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'h41, 4'hF, 32'h0);
        @(posedge clk); #1;
        check("ws0 misaligned err", 32'(bus0.err), 32'd1);
        check("ws0 misaligned ack", 32'(bus0.ack), 32'd0);
        check("ws0 misaligned dat", bus0.dat_o, 32'h12345678);
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        check("ws0 err pulse end", 32'(bus0.err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
